// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Frame data is shadowed once per scan so that input changes never tear a frame.
// Leading zeros are suppressed, and the whole display can be flashed with blink.
module seg7_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_TICKS = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd_in,
  input  logic        is_miles,
  input  logic        blink,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int SW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SLOT_MAX  = SW'(BLINK_TICKS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          mode_q, mode_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          phase_q, phase_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          fs_q, fs_d;

  logic          tick;
  logic          latch;
  logic [3:0]    blank;
  logic [3:0]    cur_code;

  // Active-low {g,f,e,d,c,b,a}; 10-14 blank, 15 is the underline separator.
  function automatic logic [6:0] glyph(input logic [3:0] c);
    logic [6:0] g;
    case (c)
      4'd0:    g = 7'b1000000;
      4'd1:    g = 7'b1111001;
      4'd2:    g = 7'b0100100;
      4'd3:    g = 7'b0110000;
      4'd4:    g = 7'b0011001;
      4'd5:    g = 7'b0010010;
      4'd6:    g = 7'b0000010;
      4'd7:    g = 7'b1111000;
      4'd8:    g = 7'b0000000;
      4'd9:    g = 7'b0010000;
      4'd15:   g = 7'b1110111;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  // Slot prescaler and digit select.
  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    presc_d = tick ? '0 : presc_q + 1'b1;
    sel_d   = tick ? sel_q + 2'd1 : sel_q;
  end

  // Shadow registers load only at the end of the last slot of a frame.
  always_comb begin
    latch    = tick && (sel_q == 2'd3);
    shadow_d = latch ? bcd_in : shadow_q;
    mode_d   = latch ? is_miles : mode_q;
    fs_d     = latch;
  end

  // Blink phase: toggles every BLINK_TICKS slots, parked at zero while blink is low.
  always_comb begin
    slot_d  = slot_q;
    phase_d = phase_q;
    if (!blink) begin
      slot_d  = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      if (slot_q == SLOT_MAX) begin
        slot_d  = '0;
        phase_d = ~phase_q;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
  end

  // Leading-zero suppression cascades down from digit 3; distance format only suppresses digit 3.
  always_comb begin
    blank[3] = (shadow_q[15:12] == 4'd0);
    blank[2] = !mode_q && (shadow_q[11:8] == 4'd0) && blank[3];
    blank[1] = !mode_q && (shadow_q[7:4]  == 4'd0) && blank[2];
    blank[0] = 1'b0;
  end

  // Next anode/segment drive for the currently selected digit.
  always_comb begin
    case (sel_q)
      2'd0:    cur_code = shadow_q[3:0];
      2'd1:    cur_code = shadow_q[7:4];
      2'd2:    cur_code = shadow_q[11:8];
      default: cur_code = shadow_q[15:12];
    endcase
    an_d  = ~(4'b0001 << sel_q);
    seg_d = blank[sel_q] ? 7'b1111111 : glyph(cur_code);
    // Blink input is used directly so that dropping it restores drive on the next edge.
    if (blink && phase_q) an_d = '1;
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      sel_q    <= '0;
      shadow_q <= '0;
      mode_q   <= 1'b0;
      slot_q   <= '0;
      phase_q  <= 1'b0;
      an_q     <= '1;
      seg_q    <= '1;
      fs_q     <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      mode_q   <= mode_d;
      slot_q   <= slot_d;
      phase_q  <= phase_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      fs_q     <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = 1'b1;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with REFRESH_DIV=4, BLINK_TICKS=2.
module tb_seg7_scan;

  logic        clk;
  logic        rst_n;
  logic [15:0] bcd_in;
  logic        is_miles;
  logic        blink;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int unsigned n_checks;
  int unsigned n_errors;

  seg7_scan #(.REFRESH_DIV(4), .BLINK_TICKS(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bcd_in(bcd_in),
    .is_miles(is_miles),
    .blink(blink),
    .an(an),
    .seg(seg),
    .dp(dp),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_digit(input string tag, input int unsigned k, input logic [6:0] e_seg);
    logic [3:0] e_an;
    e_an = ~(4'b0001 << k);
    check_eq({tag, "_an"}, {28'd0, an}, {28'd0, e_an});
    check_eq({tag, "_seg"}, {25'd0, seg}, {25'd0, e_seg});
  endtask

  // Leaves the bench at the negedge right after the frame_start edge.
  task automatic wait_frame(input string tag);
    bit found;
    found = 0;
    for (int n = 0; n < 64 && !found; n++) begin
      @(negedge clk);
      if (frame_start) found = 1;
    end
    check_eq({tag, "_frame_seen"}, {31'd0, found}, 32'd1);
  endtask

  // Called at the frame_start negedge; digit k is driven after edge F+1+4k.
  task automatic check_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3);
    @(negedge clk);
    check_digit({tag, "_d0"}, 0, e0);
    repeat (4) @(negedge clk);
    check_digit({tag, "_d1"}, 1, e1);
    repeat (4) @(negedge clk);
    check_digit({tag, "_d2"}, 2, e2);
    repeat (4) @(negedge clk);
    check_digit({tag, "_d3"}, 3, e3);
  endtask

  // Counts negedges after reset release until frame_start; checks the first drive too.
  task automatic count_first_frame(input string tag);
    int unsigned cnt;
    bit found;
    cnt = 0;
    found = 0;
    for (int n = 1; n <= 64 && !found; n++) begin
      @(negedge clk);
      if (n == 1) check_digit({tag, "_first"}, 0, 7'b1000000);
      if (frame_start) begin
        found = 1;
        cnt = n;
      end
    end
    check_eq({tag, "_latency"}, cnt, 32'd16);
  endtask

  initial begin
    logic [3:0] e_an;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    bcd_in   = 16'h0042;
    is_miles = 1'b0;
    blink    = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_an", {28'd0, an}, 32'hF);
    check_eq("rst_seg", {25'd0, seg}, 32'h7F);
    check_eq("rst_dp", {31'd0, dp}, 32'd1);
    check_eq("rst_fs", {31'd0, frame_start}, 32'd0);

    rst_n = 1'b1;
    count_first_frame("boot");
    check_frame("step42", 7'b0100100, 7'b0011001, 7'b1111111, 7'b1111111);

    bcd_in = 16'h03F5; is_miles = 1'b1;
    wait_frame("dist");
    check_frame("dist", 7'b0010010, 7'b1110111, 7'b0110000, 7'b1111111);

    bcd_in = 16'h0000; is_miles = 1'b0;
    wait_frame("zero");
    check_frame("zero", 7'b1000000, 7'b1111111, 7'b1111111, 7'b1111111);

    bcd_in = 16'h1005;
    wait_frame("s1005");
    check_frame("s1005", 7'b0010010, 7'b1000000, 7'b1000000, 7'b1111001);

    bcd_in = 16'h0A07;
    wait_frame("s0A07");
    check_frame("s0A07", 7'b1111000, 7'b1000000, 7'b1111111, 7'b1111111);

    bcd_in = 16'h0105;
    wait_frame("s0105");
    check_frame("s0105", 7'b0010010, 7'b1000000, 7'b1111001, 7'b1111111);

    // Tearing: change data and mode while sel=1.
    bcd_in = 16'h0042;
    wait_frame("tear");
    @(negedge clk);
    check_digit("tear_d0", 0, 7'b0100100);
    repeat (4) @(negedge clk);
    check_digit("tear_d1", 1, 7'b0011001);
    bcd_in = 16'h1234; is_miles = 1'b1;
    repeat (4) @(negedge clk);
    check_digit("tear_d2", 2, 7'b1111111);
    repeat (4) @(negedge clk);
    check_digit("tear_d3", 3, 7'b1111111);
    wait_frame("tear_new");
    check_digit("tear_fs_old", 3, 7'b1111111);
    check_frame("tear_new", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);

    // Blink: blank after edges F+9..F+16, normal scan otherwise.
    wait_frame("blink");
    blink = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (i >= 9 && i <= 16) e_an = 4'hF;
      else e_an = ~(4'b0001 << (((i - 1) / 4) % 4));
      check_eq($sformatf("blink_an_%0d", i), {28'd0, an}, {28'd0, e_an});
      check_eq($sformatf("blink_fs_%0d", i), {31'd0, frame_start}, {31'd0, (i == 16)});
    end
    repeat (2) @(negedge clk);
    check_eq("blink_off_phase", {28'd0, an}, 32'hF);
    blink = 1'b0;
    @(negedge clk);
    check_digit("unblink", 2, 7'b0100100);

    // Reset mid-scan at sel=2 abandons the frame and clears the shadow data.
    wait_frame("mreset");
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mreset_an", {28'd0, an}, 32'hF);
    check_eq("mreset_seg", {25'd0, seg}, 32'h7F);
    check_eq("mreset_fs", {31'd0, frame_start}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    count_first_frame("mreset");
    check_frame("after_rst", 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clocks per digit slot (legal values >= 1).
REQ-002 SHALL have parameter BLINK_TICKS, default 250, digit slots per blink half-period (legal values >= 1).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port bcd_in  input  16  four 4-bit digit codes from the BCD converter; [15:12] leftmost (digit 3), [3:0] rightmost (digit 0).
REQ-006 SHALL have port is_miles  input  1  1 = distance format (digit 1 carries the separator code 15), 0 = step-count format.
REQ-007 SHALL have port blink  input  1  1 = flash the whole display.
REQ-008 SHALL have port an  output  4  anode enables, active-low; an[k] drives digit k.
REQ-009 SHALL have port seg  output  7  segments, active-low, {g,f,e,d,c,b,a} on [6:0].
REQ-010 SHALL have port dp  output  1  decimal point, active-low; constantly 1 (off).
REQ-011 SHALL have port frame_start  output  1  one-cycle pulse that is high in the cycle in which new shadow data takes effect.

Function
REQ-012 Prescaler: counter 0..REFRESH_DIV-1; tick = (count == REFRESH_DIV-1); the counter wraps to 0 on tick; with REFRESH_DIV=1, tick is high every cycle.
REQ-013 Digit select sel (2 bits): on tick, sel advances 0->1->2->3->0; otherwise sel holds.
REQ-014 Frame latch: on the edge where tick && sel==3, the shadow data register loads bcd_in, the shadow mode register loads is_miles, and frame_start is set to 1; on every other edge frame_start is cleared to 0.
REQ-015 bcd_in and is_miles changes between frame latches SHALL NOT affect the displayed data (no tearing).
REQ-016 Decode of code c: codes 0-9 produce standard glyphs ('0'=1000000, '2'=0100100, '4'=0011001, '5'=0010010, '3'=0110000); codes 10-14 produce blank (1111111); code 15 produces the underline, segment d only (1110111).
REQ-017 Step-format blanking: digit 3 is blank if its code is 0; digit 2 is blank if its code is 0 and digit 3 is blanked; digit 1 is blank if its code is 0 and digit 2 is blanked; digit 0 is never blanked.
REQ-018 Distance-format blanking: only digit 3 is blanked, when its code is 0; digits 2..0 are always shown.
REQ-019 an and seg SHALL be registered with one cycle of latency: the value after edge N reflects sel, shadow data, shadow mode and blink phase as they stood after edge N-1.
REQ-020 Digit drive: for the active sel=k, an has bit k = 0 and all other bits = 1; a blanked digit keeps its anode active and drives seg=1111111.
REQ-021 Blink phase: a slot counter counts ticks 0..BLINK_TICKS-1 and toggles the phase bit on wrap; while blink=0, the slot counter and the phase bit are held at 0.
REQ-022 While blink=1 and phase=1, an SHALL be 1111 (seg value is don't-care); scanning and frame latching SHALL continue unaffected.
REQ-023 Deasserting blink mid-phase SHALL restore normal anode drive on the next registered update.

Reset
REQ-024 While rst_n=0, asynchronously: prescaler=0, sel=0, shadow data=16'h0000, shadow mode=0, slot counter=0, phase=0, an=1111, seg=1111111, dp=1, frame_start=0.
REQ-025 After rst_n rises, the first tick SHALL occur REFRESH_DIV clocks later, and the first frame_start SHALL occur at the fourth tick.
REQ-026 Reset asserted mid-scan or mid-blink SHALL abandon the current frame, with no partial latch of the shadow registers.

Verification (REFRESH_DIV=4, BLINK_TICKS=2)
REQ-027 Reset: pulse rst_n low at sel=2 -> an=1111, seg=1111111 immediately; after release, the first frame_start pulse occurs 16 clocks later.
REQ-028 Step format: bcd_in=16'h0042, is_miles=0 -> per frame, digit 0 shows 0100100, digit 1 shows 0011001, and digits 2 and 3 are blank with their anodes low.
REQ-029 Distance format: bcd_in=16'h03F5, is_miles=1 -> digit 0 shows 0010010, digit 1 shows 1110111, digit 2 shows 0110000, digit 3 is blank.
REQ-030 Zero value: bcd_in=16'h0000, is_miles=0 -> only digit 0 shows 1000000; digits 1-3 are blank.
REQ-031 No tearing: change bcd_in from 16'h0042 to 16'h0099 while sel=1 -> digits 2 and 3 of that frame still show the old data; the new value appears only from the cycle after frame_start.
REQ-032 Blink: blink=1 -> an=1111 for 8-clock windows alternating with 8-clock windows of normal scan; after blink=0, scanning resumes within 1 clock.
